program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Writer side of the CPU's 16x8 instruction memory. Accepts a framed program over a byte-wide valid/ready stream and writes each instruction into the memory write port. It then zero-fills the unused addresses. The CPU is held in reset (cpu_hold) until a complete, checksum-valid image is resident. Sits between the host/debug byte source and the instruction memory shared with the CPU fetch port.

Parameters:
ADDR_WIDTH, 4, instruction memory address width; depth = 2**ADDR_WIDTH (16)
DATA_WIDTH, 8, instruction width ([7:4] opcode, [3:0] operand)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load session
in_valid  input  1  byte source has in_data available
in_data  input  DATA_WIDTH  stream byte
in_ready  output  1  loader can accept a byte this cycle
mem_wr_en  output  1  instruction memory write strobe
mem_wr_addr  output  ADDR_WIDTH  write address
mem_wr_data  output  DATA_WIDTH  write data
cpu_hold  output  1  active-high reset to the CPU; 1 while no valid image is resident
busy  output  1  session in progress (any state other than IDLE/DONE/ERROR)
done  output  1  image loaded and verified
error  output  1  session aborted (bad count or checksum mismatch)

Behaviour:
- Reset values: in_ready=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, cpu_hold=1, busy=0, done=0, error=0; state=IDLE; count, index and checksum accumulator cleared.
- Handshake: a byte transfers on the posedge where in_valid && in_ready. in_ready is a registered state decode: 1 in HEADER/DATA/CHECK, 0 elsewhere. in_data is ignored when not transferred.
- Stream frame: count byte N, then N instruction bytes, then a checksum byte equal to the XOR of the N instruction bytes.
- States:
  - IDLE/DONE/ERROR: start -> HEADER; clears done, error and the accumulator; sets cpu_hold=1, busy=1. start is ignored in HEADER/DATA/CHECK/FILL.
  - HEADER: on transfer, N is valid only if in_data[7:5]==0 and 1<=in_data[4:0]<=16. Valid -> DATA with index=0. Invalid -> ERROR.
  - DATA: on each transfer, drive mem_wr_en=1, mem_wr_addr=index, mem_wr_data=in_data on the following cycle (1-cycle registered latency). acc ^= in_data; index++. After the Nth byte -> CHECK.
  - CHECK: on transfer, in_data==acc -> FILL if N<16, else DONE. Mismatch -> ERROR.
  - FILL: one write per cycle of 0x00 (NOP) at addresses N..15, mem_wr_en continuously high. After address 15 -> DONE. No stream bytes are accepted.
  - DONE: done=1, busy=0, cpu_hold=0 (deasserts the cycle after entering DONE, and only after the last write has been issued).
  - ERROR: error=1, busy=0, cpu_hold stays 1. Memory contents are partial and must not be executed.
- mem_wr_en is high only for the single cycle after a DATA transfer, or during FILL; never in HEADER, CHECK, IDLE, DONE or ERROR.
- Index is 5 bits internally so N=16 does not wrap. mem_wr_addr is its low ADDR_WIDTH bits.
- Stalls: in_valid low for any number of cycles pauses the session with no timeout. State and outputs are held.
- Reset mid-session (asynchronous): immediately returns to reset values. Any write in flight is dropped. cpu_hold=1.
- start coincident with reset: reset wins.

Test Plan:
- Nominal load: start; stream 0x05,0x13,0x22,0x30,0x50,0x44,0x15 with in_valid held high -> writes 0x13@0 .. 0x44@4, then 0x00@5..15 over 11 consecutive cycles, then done=1, cpu_hold=0. With the CPU attached, output_data=5 after execution.
- Full image N=16: stream 0x10, bytes 0x10..0x1F, checksum 0x00 -> 16 writes, no FILL cycles, done=1.
- Bad checksum: same as the nominal stream but checksum 0x14 -> error=1, cpu_hold=1, no FILL writes, done=0.
- Bad count: count bytes 0x00, 0x11 and 0x21 (separate sessions) -> error=1 after the header, no mem_wr_en pulses.
- Backpressure/stall: nominal stream with in_valid toggled randomly -> identical write sequence. No writes occur when no transfer has occurred. start pulses mid-session are ignored.
- Reset mid-DATA after 2 bytes: assert reset -> all outputs at reset values in the same cycle. A following start plus nominal stream completes normally.

Source files
------------

// File: rtl/program_loader.sv
`timescale 1ns/1ps
// program_loader: receives a framed program (count, N instructions, XOR
// checksum) over a byte stream, writes it into the instruction memory,
// zero-fills the unused tail and releases the CPU only once the image is
// complete and verified.
//
// Stream handshake: a byte moves on the rising clk edge where
// in_valid && in_ready are both high; in_ready depends only on state, never
// on in_valid, and in_data is ignored on any edge without a transfer.
module program_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // One extra bit so a full-depth count/index does not wrap to zero.
    localparam int IW = ADDR_WIDTH + 1;
    localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);
    localparam logic [IW-1:0] LAST_I  = IW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        CHECK,
        FILL,
        DONE,
        ERROR
    } state_t;

    // state is kept as a named internal signal so checkers can bind to it.
    state_t                state, state_n;
    logic [IW-1:0]         count, count_n;
    logic [IW-1:0]         index, index_n;
    logic [DATA_WIDTH-1:0] acc, acc_n;

    logic                  in_ready_n, busy_n, done_n, error_n, cpu_hold_n;
    logic                  wr_en_n;
    logic [ADDR_WIDTH-1:0] wr_addr_n;
    logic [DATA_WIDTH-1:0] wr_data_n;

    logic                  xfer;
    logic                  header_ok;

    assign xfer = in_valid && in_ready;

    // Count byte must be 1..DEPTH with no stray high bits.
    assign header_ok = (in_data[DATA_WIDTH-1:IW] == '0) &&
                       (in_data[IW-1:0] != '0) &&
                       (in_data[IW-1:0] <= DEPTH_I);

    // State, bookkeeping and all outputs are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            index       <= '0;
            acc         <= '0;
            in_ready    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            cpu_hold    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            index       <= index_n;
            acc         <= acc_n;
            in_ready    <= in_ready_n;
            mem_wr_en   <= wr_en_n;
            mem_wr_addr <= wr_addr_n;
            mem_wr_data <= wr_data_n;
            cpu_hold    <= cpu_hold_n;
            busy        <= busy_n;
            done        <= done_n;
            error       <= error_n;
        end
    end

    // Next-state and next-output decode; everything holds unless a case moves it.
    always_comb begin
        state_n    = state;
        count_n    = count;
        index_n    = index;
        acc_n      = acc;
        wr_en_n    = 1'b0;
        wr_addr_n  = mem_wr_addr;
        wr_data_n  = mem_wr_data;
        cpu_hold_n = cpu_hold;
        done_n     = done;
        error_n    = error;

        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_n    = HEADER;
                    count_n    = '0;
                    index_n    = '0;
                    acc_n      = '0;
                    done_n     = 1'b0;
                    error_n    = 1'b0;
                    cpu_hold_n = 1'b1;
                end else if (state == DONE) begin
                    // Released one cycle after entry, after the last write.
                    done_n     = 1'b1;
                    cpu_hold_n = 1'b0;
                end else if (state == ERROR) begin
                    error_n    = 1'b1;
                    cpu_hold_n = 1'b1;
                end
            end
            HEADER: begin
                if (xfer) begin
                    if (header_ok) begin
                        count_n = in_data[IW-1:0];
                        index_n = '0;
                        state_n = DATA;
                    end else begin
                        state_n = ERROR;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = index[ADDR_WIDTH-1:0];
                    wr_data_n = in_data;
                    acc_n     = acc ^ in_data;
                    index_n   = index + 1'b1;
                    if (index + 1'b1 == count) state_n = CHECK;
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (in_data == acc) begin
                        // index already equals count: first fill address.
                        state_n = (count < DEPTH_I) ? FILL : DONE;
                    end else begin
                        state_n = ERROR;
                    end
                end
            end
            FILL: begin
                wr_en_n   = 1'b1;
                wr_addr_n = index[ADDR_WIDTH-1:0];
                wr_data_n = '0;
                index_n   = index + 1'b1;
                if (index == LAST_I) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase

        in_ready_n = (state_n == HEADER) || (state_n == DATA) || (state_n == CHECK);
        busy_n     = in_ready_n || (state_n == FILL);
    end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
// Bench for program_loader: drives framed sessions, predicts memory writes
// into a queue and compares every observed write against it.
module tb_program_loader;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;

  int checks   = 0;
  int failures = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    frame_q[$];

  program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .done(done),
    .error(error)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every observed write must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && mem_wr_en) begin
      check_eq("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check_eq("wr_addr_data", {mem_wr_addr, mem_wr_data}, exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_wr_en"}, mem_wr_en, 0);
    check_eq({tag, "_wr_addr"}, mem_wr_addr, 0);
    check_eq({tag, "_wr_data"}, mem_wr_data, 0);
    check_eq({tag, "_cpu_hold"}, cpu_hold, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_error"}, error, 0);
  endtask

  // driver: present one byte, hold it until accepted; called at a negedge
  task automatic send_byte(input logic [DW-1:0] b, input bit stall);
    int guard = 0;
    if (stall) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom_range(0, 255));
        start    = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        start = 1'b0;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_eq("ready_timeout", guard, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_hold", cpu_hold, 1);
    check_eq("start_done", done, 0);
    check_eq("start_error", error, 0);
  endtask

  // one full session from frame_q; predictions come from the frame itself
  task automatic run_session(input string tag, input bit stall);
    int n;
    int g;
    bit hdr_ok;
    bit ok;
    logic [DW-1:0] x;
    pulse_start();
    n      = int'(frame_q[0]);
    hdr_ok = (n >= 1) && (n <= 16);
    ok     = 1'b0;
    send_byte(frame_q[0], stall);
    if (hdr_ok) begin
      x = '0;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({AW'(i), frame_q[1 + i]});
        x = x ^ frame_q[1 + i];
        send_byte(frame_q[1 + i], stall);
      end
      ok = (frame_q[1 + n] == x);
      if (ok) begin
        for (int a = n; a < 16; a++) exp_q.push_back({AW'(a), 8'h00});
      end
      send_byte(frame_q[1 + n], stall);
    end
    g = 0;
    while (!(done || error) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq({tag, "_end_timeout"}, g < 100, 1);
    check_eq({tag, "_done"}, done, ok);
    check_eq({tag, "_error"}, error, !ok);
    check_eq({tag, "_cpu_hold"}, cpu_hold, !ok);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_writes_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_nominal(input logic [DW-1:0] csum);
    frame_q = '{8'h05, 8'h13, 8'h22, 8'h30, 8'h50, 8'h44, csum};
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check_reset_values("por");

    // start coincident with reset is lost
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_eq("start_in_reset_busy", busy, 0);
    check_eq("start_in_reset_ready", in_ready, 0);

    // nominal load
    load_nominal(8'h15);
    run_session("nominal", 1'b0);

    // full image, no fill
    frame_q = '{8'h10};
    for (int i = 0; i < 16; i++) frame_q.push_back(8'h10 + DW'(i));
    frame_q.push_back(8'h00);
    run_session("full", 1'b0);

    // bad checksum
    load_nominal(8'h14);
    run_session("bad_csum", 1'b0);

    // bad counts
    frame_q = '{8'h00};
    run_session("bad_cnt00", 1'b0);
    frame_q = '{8'h11};
    run_session("bad_cnt11", 1'b0);
    frame_q = '{8'h21};
    run_session("bad_cnt21", 1'b0);

    // stalls and ignored start pulses
    for (int r = 0; r < 3; r++) begin
      load_nominal(8'h15);
      run_session("stall", 1'b1);
    end

    // reset mid-DATA with a write in flight
    pulse_start();
    send_byte(8'h05, 1'b0);
    exp_q.push_back({4'd0, 8'h13});
    send_byte(8'h13, 1'b0);
    exp_q.push_back({4'd1, 8'h22});
    send_byte(8'h22, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h30;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_reset_writes_left", exp_q.size(), 0);
    exp_q.delete();
    load_nominal(8'h15);
    run_session("after_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
